// File: rtl/park_pkg.sv
// ============================================================================
// park_pkg : lane FSM state encoding and width helpers for park_lane_counter
// Rev 1.0
// ============================================================================
`default_nettype none

package park_pkg;

  localparam int SYNC_STAGES = 2;

  typedef logic [2:0] lane_state_t;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_EN_O  = 3'd1;
  localparam logic [2:0] ST_EN_OI = 3'd2;
  localparam logic [2:0] ST_EN_I  = 3'd3;
  localparam logic [2:0] ST_EX_I  = 3'd4;
  localparam logic [2:0] ST_EX_OI = 3'd5;
  localparam logic [2:0] ST_EX_O  = 3'd6;

  // Bits needed to hold values 0..n (never less than one bit).
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/park_lane_fsm.sv
// ============================================================================
// park_lane_fsm : one gate - sensor sync/debounce, direction FSM, event pulses
// Rev 1.0
// ============================================================================
`default_nettype none

module park_lane_fsm
  import park_pkg::*;
#(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic pout_i,
  input  logic pin_i,
  output logic entry_o,
  output logic exit_o
);

  localparam int DW = cnt_width(DEB_CYCLES);

  logic [1:0] raw;
  logic [1:0] deb;

  assign raw = {pout_i, pin_i};

  for (genvar g = 0; g < 2; g++) begin : g_deb
    logic [SYNC_STAGES-1:0] sync_q;
    logic [DW-1:0]          cnt_q;
    logic                   deb_q;

    // Any sample agreeing with the accepted level restarts the stability run.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        sync_q <= '0;
        cnt_q  <= '0;
        deb_q  <= 1'b0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], raw[g]};
        if (sync_q[SYNC_STAGES-1] == deb_q) begin
          cnt_q <= '0;
        end else if (cnt_q == DW'(DEB_CYCLES - 1)) begin
          deb_q <= sync_q[SYNC_STAGES-1];
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end

    assign deb[g] = deb_q;
  end

  lane_state_t state_q, state_d;
  logic        entry_q, entry_d;
  logic        exit_q,  exit_d;

  always_comb begin
    state_d = state_q;
    entry_d = 1'b0;
    exit_d  = 1'b0;
    case (state_q)
      ST_IDLE:  if (deb == 2'b10) state_d = ST_EN_O;
                else if (deb == 2'b01) state_d = ST_EX_I;
      ST_EN_O:  if (deb == 2'b11) state_d = ST_EN_OI;
                else if (deb == 2'b00) state_d = ST_IDLE;
      ST_EN_OI: if (deb == 2'b01) state_d = ST_EN_I;
                else if (deb == 2'b10) state_d = ST_EN_O;
                else if (deb == 2'b00) state_d = ST_IDLE;
      ST_EN_I:  if (deb == 2'b00) begin
                  state_d = ST_IDLE;
                  entry_d = 1'b1;
                end else if (deb == 2'b11) state_d = ST_EN_OI;
      ST_EX_I:  if (deb == 2'b11) state_d = ST_EX_OI;
                else if (deb == 2'b00) state_d = ST_IDLE;
      ST_EX_OI: if (deb == 2'b10) state_d = ST_EX_O;
                else if (deb == 2'b01) state_d = ST_EX_I;
                else if (deb == 2'b00) state_d = ST_IDLE;
      ST_EX_O:  if (deb == 2'b00) begin
                  state_d = ST_IDLE;
                  exit_d  = 1'b1;
                end else if (deb == 2'b11) state_d = ST_EX_OI;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      entry_q <= 1'b0;
      exit_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      entry_q <= entry_d;
      exit_q  <= exit_d;
    end
  end

  assign entry_o = entry_q;
  assign exit_o  = exit_q;

endmodule

`default_nettype wire

// File: rtl/park_lane_counter.sv
// ============================================================================
// park_lane_counter : multi-lane car park occupancy counter with capacity flags
// Rev 1.0
// ============================================================================
`default_nettype none

module park_lane_counter
  import park_pkg::*;
#(
  parameter int LANES      = 2,
  parameter int CNT_W      = 8,
  parameter int CAPACITY   = 200,
  parameter int DEB_CYCLES = 4
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic [LANES-1:0] Pout,
  input  logic [LANES-1:0] Pin,
  input  logic             Clear,
  output logic [CNT_W-1:0] CarCount,
  output logic             Full,
  output logic             Empty,
  output logic [LANES-1:0] EntryPulse,
  output logic [LANES-1:0] ExitPulse,
  output logic             Overflow,
  output logic             Underflow
);

  localparam int PC_W = cnt_width(LANES);
  localparam int SW   = CNT_W + 4;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    park_lane_fsm #(
      .DEB_CYCLES (DEB_CYCLES)
    ) u_lane (
      .clk_i   (Clk),
      .rst_n_i (Reset_n),
      .pout_i  (Pout[l]),
      .pin_i   (Pin[l]),
      .entry_o (EntryPulse[l]),
      .exit_o  (ExitPulse[l])
    );
  end

  logic [PC_W-1:0]     ent_cnt, ext_cnt;
  logic signed [SW-1:0] sum;
  logic signed [SW-1:0] cap;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                ovf_q, ovf_d;
  logic                udf_q, udf_d;

  always_comb begin
    ent_cnt = '0;
    ext_cnt = '0;
    for (int l = 0; l < LANES; l++) begin
      ent_cnt = ent_cnt + PC_W'(EntryPulse[l]);
      ext_cnt = ext_cnt + PC_W'(ExitPulse[l]);
    end
  end

  // Entries and exits net out first, so only the net result can saturate.
  assign sum = $signed(SW'(count_q)) + $signed(SW'(ent_cnt)) - $signed(SW'(ext_cnt));
  assign cap = $signed(SW'(CAPACITY));

  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    if (Clear) begin
      count_d = '0;
      ovf_d   = 1'b0;
      udf_d   = 1'b0;
    end else if (sum > cap) begin
      count_d = CNT_W'(CAPACITY);
      ovf_d   = 1'b1;
    end else if (sum[SW-1]) begin
      count_d = '0;
      udf_d   = 1'b1;
    end else begin
      count_d = sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  assign CarCount  = count_q;
  assign Full      = (count_q == CNT_W'(CAPACITY));
  assign Empty     = (count_q == '0);
  assign Overflow  = ovf_q;
  assign Underflow = udf_q;

endmodule

`default_nettype wire
